// File: rtl/tap_shift_buffer.sv
// rtl/tap_shift_buffer.sv - word-wide tap-delay line with evicted-sample output port and fill counter
module tap_shift_buffer #(
    parameter int NBITS = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         load,
    input  logic [DEPTH*NBITS-1:0]       Data_load,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NBITS-1:0]             Data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NBITS-1:0]             Data_out,
    output logic [DEPTH*NBITS-1:0]       r,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         primed
);

    localparam int M  = DEPTH * NBITS;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic push;
    logic drain;
    logic full;

    // The output slot can take a new evicted word when it is empty or being consumed now.
    assign in_ready = !out_valid || out_ready;
    // Clear and load both take precedence over a shift, so they mask the handshake.
    assign push     = in_valid && in_ready && !load && !clear;
    assign drain    = out_valid && out_ready;
    assign full     = (count == FULL);
    assign primed   = full;

    // Tap vector: word 0 is the newest sample, so a shift moves words toward the top.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r <= '0;
        end else if (clear) begin
            r <= '0;
        end else if (load) begin
            r <= Data_load;
        end else if (push) begin
            r <= {r[M-NBITS-1:0], Data_in};
        end
    end

    // Fill counter saturates at DEPTH; a preset image counts as a fully primed regressor.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= FULL;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end
    end

    // Evicted-sample port: only a word pushed out of a full line is a real sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Data_out  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            Data_out  <= '0;
            out_valid <= 1'b0;
        end else if (push) begin
            Data_out  <= r[M-1 -: NBITS];
            out_valid <= full;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tap_shift_buffer.sv
// tb/tb_tap_shift_buffer.sv - table-driven bench for tap_shift_buffer
module tb_tap_shift_buffer;

    localparam int NBITS = 32;
    localparam int DEPTH = 4;
    localparam int M     = NBITS * DEPTH;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clock = 1'b0;
    logic            reset;
    logic            clear;
    logic            load;
    logic [M-1:0]    Data_load;
    logic            in_valid;
    logic            in_ready;
    logic [NBITS-1:0] Data_in;
    logic            out_valid;
    logic            out_ready;
    logic [NBITS-1:0] Data_out;
    logic [M-1:0]    r;
    logic [CW-1:0]   count;
    logic            primed;

    int n_cmp  = 0;
    int n_fail = 0;

    tap_shift_buffer #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .load      (load),
        .Data_load (Data_load),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data_in   (Data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Data_out  (Data_out),
        .r         (r),
        .count     (count),
        .primed    (primed)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         clr;
        logic         ld;
        logic         iv;
        logic         ordy;
        logic [31:0]  din;
        logic [127:0] dload;
        logic [127:0] e_r;
        logic [2:0]   e_cnt;
        logic         e_primed;
        logic         e_ov;
        logic [31:0]  e_dout;
        logic         e_irdy;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [127:0] e_r, input logic [2:0] e_cnt,
                             input logic e_primed, input logic e_ov, input logic [31:0] e_dout,
                             input logic e_irdy);
        check({tag, ".r"},         r,                e_r);
        check({tag, ".count"},     128'(count),      128'(e_cnt));
        check({tag, ".primed"},    128'(primed),     128'(e_primed));
        check({tag, ".out_valid"}, 128'(out_valid),  128'(e_ov));
        check({tag, ".Data_out"},  128'(Data_out),   128'(e_dout));
        check({tag, ".in_ready"},  128'(in_ready),   128'(e_irdy));
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge clock);
        clear = 0; load = 0; in_valid = 1; out_ready = 1; Data_in = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //        clr ld iv ordy din           dload                                   e_r                                     cnt pr ov dout          irdy
        vecs[0]  = '{0, 0, 1, 1, 32'h11,       128'h0, 128'h00000000_00000000_00000000_00000011, 3'd1, 0, 0, 32'h0,        1};
        vecs[1]  = '{0, 0, 1, 1, 32'h22,       128'h0, 128'h00000000_00000000_00000011_00000022, 3'd2, 0, 0, 32'h0,        1};
        vecs[2]  = '{0, 0, 1, 1, 32'h33,       128'h0, 128'h00000000_00000011_00000022_00000033, 3'd3, 0, 0, 32'h0,        1};
        vecs[3]  = '{0, 0, 1, 1, 32'h44,       128'h0, 128'h00000011_00000022_00000033_00000044, 3'd4, 1, 0, 32'h0,        1};
        vecs[4]  = '{0, 0, 1, 1, 32'h55,       128'h0, 128'h00000022_00000033_00000044_00000055, 3'd4, 1, 1, 32'h11,       1};
        vecs[5]  = '{0, 0, 1, 0, 32'h66,       128'h0, 128'h00000022_00000033_00000044_00000055, 3'd4, 1, 1, 32'h11,       0};
        vecs[6]  = '{0, 0, 1, 0, 32'h66,       128'h0, 128'h00000022_00000033_00000044_00000055, 3'd4, 1, 1, 32'h11,       0};
        vecs[7]  = '{0, 0, 1, 0, 32'h66,       128'h0, 128'h00000022_00000033_00000044_00000055, 3'd4, 1, 1, 32'h11,       0};
        vecs[8]  = '{0, 0, 1, 1, 32'h66,       128'h0, 128'h00000033_00000044_00000055_00000066, 3'd4, 1, 1, 32'h22,       1};
        vecs[9]  = '{0, 0, 0, 1, 32'h0,        128'h0, 128'h00000033_00000044_00000055_00000066, 3'd4, 1, 0, 32'h22,       1};
        vecs[10] = '{0, 1, 0, 0, 32'h0,        128'h0000000A_0000000B_0000000C_0000000D,
                                                       128'h0000000A_0000000B_0000000C_0000000D, 3'd4, 1, 0, 32'h22,       1};
        vecs[11] = '{0, 0, 1, 1, 32'hE,        128'h0, 128'h0000000B_0000000C_0000000D_0000000E, 3'd4, 1, 1, 32'hA,        1};
        vecs[12] = '{0, 1, 0, 0, 32'h0,        128'h00000001_00000002_00000003_00000004,
                                                       128'h00000001_00000002_00000003_00000004, 3'd4, 1, 1, 32'hA,        0};
        vecs[13] = '{0, 1, 1, 1, 32'h99,       128'h00000005_00000006_00000007_00000008,
                                                       128'h00000005_00000006_00000007_00000008, 3'd4, 1, 0, 32'hA,        1};
        vecs[14] = '{0, 0, 1, 0, 32'h77,       128'h0, 128'h00000006_00000007_00000008_00000077, 3'd4, 1, 1, 32'h5,        0};
        vecs[15] = '{1, 1, 1, 1, 32'hCC,       128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                                                       128'h0,                                   3'd0, 0, 0, 32'h0,        1};
        vecs[16] = '{0, 0, 1, 1, 32'hAB,       128'h0, 128'h00000000_00000000_00000000_000000AB, 3'd1, 0, 0, 32'h0,        1};

        reset = 0; clear = 0; load = 0; Data_load = '0;
        in_valid = 0; Data_in = '0; out_ready = 1;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset", 128'h0, 3'd0, 0, 0, 32'h0, 1);
        @(negedge clock);
        reset = 1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            clear     = vecs[i].clr;
            load      = vecs[i].ld;
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            Data_in   = vecs[i].din;
            Data_load = vecs[i].dload;
            @(posedge clock);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_r, vecs[i].e_cnt, vecs[i].e_primed,
                      vecs[i].e_ov, vecs[i].e_dout, vecs[i].e_irdy);
        end

        // Refill, then make the evicted AB pending and probe in_ready combinationally.
        push_word(32'h1);
        push_word(32'h2);
        push_word(32'h3);
        push_word(32'h4);
        check("refill.r", r, 128'h00000001_00000002_00000003_00000004);
        @(negedge clock);
        in_valid = 0; out_ready = 0;
        #1;
        check("hold.out_valid", 128'(out_valid), 128'(1'b1));
        check("hold.Data_out",  128'(Data_out),  128'h000000AB);
        check("hold.in_ready",  128'(in_ready),  128'(1'b0));
        in_valid = 1;
        #1;
        check("hold_iv.in_ready", 128'(in_ready), 128'(1'b0));
        out_ready = 1;
        #1;
        check("comb.in_ready",  128'(in_ready),  128'(1'b1));
        in_valid = 0;

        // Asynchronous reset between edges while a sample is pending.
        out_ready = 0;
        @(posedge clock);
        #2;
        reset = 0;
        #1;
        check_all("async_rst", 128'h0, 3'd0, 0, 0, 32'h0, 1);
        @(posedge clock);
        #1;
        check("async_rst_hold.count", 128'(count), 128'h0);
        @(negedge clock);
        reset = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
